sao_lcu_filter: RTL

//  Parametrised HEVC sample-adaptive-offset filter. Buffers one LCU (raster order) from the pixel stream,

---
 rtl/sao_lcu_filter.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/sao_lcu_filter.sv
// HEVC SAO filter: buffers one LCU, applies band / edge offset with clipping, writes it to frame SRAM.
// Optional macro SAO_DIAG_EN enables the diagonal edge classes (2/3); without it they pass through.
module sao_lcu_filter #(
    parameter int BIT_DEPTH  = 8,
    parameter int LCU_LOG2   = 4,
    parameter int PIC_W_LOG2 = 7,
    parameter int PIC_LCUS   = 64,
    parameter int IDX_W      = 3,
    parameter int ADDR_W     = 14
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_en,
    input  logic [BIT_DEPTH-1:0] din,
    input  logic [1:0]           sao_type,
    input  logic [4:0]           sao_band_pos,
    input  logic [1:0]           sao_eo_class,
    input  logic [15:0]          sao_offset,
    input  logic [IDX_W-1:0]     lcu_x,
    input  logic [IDX_W-1:0]     lcu_y,
    output logic                 busy,
    output logic                 finish,
    output logic                 sram_cen,
    output logic                 sram_wen,
    output logic [ADDR_W-1:0]    sram_addr,
    output logic [BIT_DEPTH-1:0] sram_d
);
    localparam int N  = 1 << (2 * LCU_LOG2);
    localparam int CW = 2 * LCU_LOG2;
    localparam int LW = (PIC_LCUS > 1) ? $clog2(PIC_LCUS) : 1;
    localparam int SW = BIT_DEPTH + 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_PROC = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CW-1:0]       CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0]       CNT_ONE  = CW'(1);
    localparam logic [LW-1:0]       LCU_LAST = LW'(PIC_LCUS - 1);
    localparam logic [LW-1:0]       LCU_ONE  = LW'(1);
    localparam logic [LCU_LOG2-1:0] POS_ONE  = LCU_LOG2'(1);
    localparam logic [LCU_LOG2-1:0] POS_MAX  = '1;
    localparam logic signed [SW-1:0] MAX_S   = SW'((1 << BIT_DEPTH) - 1);

`ifdef SAO_DIAG_EN
    localparam bit DIAG_EN = 1'b1;
`else
    localparam bit DIAG_EN = 1'b0;
`endif

    logic [1:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [LW-1:0]        lcu_cnt_q, lcu_cnt_d;
    logic                 busy_q, busy_d;
    logic [1:0]           type_q, type_d;
    logic [4:0]           band_pos_q, band_pos_d;
    logic [1:0]           eo_class_q, eo_class_d;
    logic [15:0]          offset_q, offset_d;
    logic [IDX_W-1:0]     lcu_x_q, lcu_x_d;
    logic [IDX_W-1:0]     lcu_y_q, lcu_y_d;

    logic [BIT_DEPTH-1:0] pix_mem [N];
    logic                 accept;

    assign accept = in_en && !busy_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lcu_cnt_d  = lcu_cnt_q;
        type_d     = type_q;
        band_pos_d = band_pos_q;
        eo_class_d = eo_class_q;
        offset_d   = offset_q;
        lcu_x_d    = lcu_x_q;
        lcu_y_d    = lcu_y_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_LOAD;
                cnt_d   = '0;
            end
            S_LOAD: begin
                if (accept) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == '0) begin
                        type_d     = sao_type;
                        band_pos_d = sao_band_pos;
                        eo_class_d = sao_eo_class;
                        offset_d   = sao_offset;
                        lcu_x_d    = lcu_x;
                        lcu_y_d    = lcu_y;
                    end
                    if (cnt_q == CNT_LAST) state_d = S_PROC;
                end
            end
            S_PROC: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    if (lcu_cnt_q == LCU_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_LOAD;
                        lcu_cnt_d = lcu_cnt_q + LCU_ONE;
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                lcu_cnt_d = '0;
            end
        endcase
        busy_d = (state_d != S_LOAD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            lcu_cnt_q  <= '0;
            busy_q     <= 1'b1;
            type_q     <= '0;
            band_pos_q <= '0;
            eo_class_q <= '0;
            offset_q   <= '0;
            lcu_x_q    <= '0;
            lcu_y_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lcu_cnt_q  <= lcu_cnt_d;
            busy_q     <= busy_d;
            type_q     <= type_d;
            band_pos_q <= band_pos_d;
            eo_class_q <= eo_class_d;
            offset_q   <= offset_d;
            lcu_x_q    <= lcu_x_d;
            lcu_y_q    <= lcu_y_d;
        end
    end

    // Pixel buffer needs three reads per cycle (centre + two neighbours), so it stays in flops.
    always_ff @(posedge clk) begin
        if (accept) pix_mem[cnt_q] <= din;
    end

    logic [3:0] off_arr [4];
    for (genvar gi = 0; gi < 4; gi++) begin : g_off
        assign off_arr[gi] = offset_q[15 - 4 * gi -: 4];
    end

    logic [LCU_LOG2-1:0]  row, col, a_row, a_col, b_row, b_col;
    logic [BIT_DEPTH-1:0] c_pix, a_pix, b_pix, res;
    logic                 border, edge_hit, apply;
    logic [1:0]           edge_idx, off_idx;
    logic [4:0]           band_k;
    logic signed [SW-1:0] off_ext, sum;
    logic [ADDR_W-1:0]    addr_full;

    assign row = cnt_q[CW-1:LCU_LOG2];
    assign col = cnt_q[LCU_LOG2-1:0];

    always_comb begin
        a_row = row;
        a_col = col;
        b_row = row;
        b_col = col;
        case (eo_class_q)
            2'd0: begin
                a_col = col - POS_ONE;  b_col = col + POS_ONE;
                border = (col == '0) || (col == POS_MAX);
            end
            2'd1: begin
                a_row = row - POS_ONE;  b_row = row + POS_ONE;
                border = (row == '0) || (row == POS_MAX);
            end
            2'd2: begin
                a_row = row - POS_ONE;  a_col = col - POS_ONE;
                b_row = row + POS_ONE;  b_col = col + POS_ONE;
                border = (row == '0) || (row == POS_MAX) || (col == '0) || (col == POS_MAX);
            end
            default: begin
                a_row = row - POS_ONE;  a_col = col + POS_ONE;
                b_row = row + POS_ONE;  b_col = col - POS_ONE;
                border = (row == '0) || (row == POS_MAX) || (col == '0) || (col == POS_MAX);
            end
        endcase
    end

    assign c_pix = pix_mem[cnt_q];
    assign a_pix = pix_mem[{a_row, a_col}];
    assign b_pix = pix_mem[{b_row, b_col}];

    always_comb begin
        edge_hit = 1'b1;
        edge_idx = 2'd0;
        if (c_pix < a_pix && c_pix < b_pix)
            edge_idx = 2'd0;
        else if ((c_pix < a_pix && c_pix == b_pix) || (c_pix == a_pix && c_pix < b_pix))
            edge_idx = 2'd1;
        else if ((c_pix > a_pix && c_pix == b_pix) || (c_pix == a_pix && c_pix > b_pix))
            edge_idx = 2'd2;
        else if (c_pix > a_pix && c_pix > b_pix)
            edge_idx = 2'd3;
        else
            edge_hit = 1'b0;
    end

    // Band index wraps modulo 32, so band_pos near 31 can cover the lowest bands.
    assign band_k = c_pix[BIT_DEPTH-1 -: 5] - band_pos_q;

    always_comb begin
        apply   = 1'b0;
        off_idx = 2'd0;
        case (type_q)
            2'd1: begin
                apply   = (band_k < 5'd4);
                off_idx = band_k[1:0];
            end
            2'd2: begin
                apply   = edge_hit && !border && (DIAG_EN || !eo_class_q[1]);
                off_idx = edge_idx;
            end
            default: apply = 1'b0;
        endcase
    end

    assign off_ext = {{(SW - 4){off_arr[off_idx][3]}}, off_arr[off_idx]} <<< (BIT_DEPTH - 8);
    assign sum     = $signed({2'b00, c_pix}) + off_ext;

    always_comb begin
        res = c_pix;
        if (apply) begin
            if (sum[SW-1])        res = '0;
            else if (sum > MAX_S) res = '1;
            else                  res = sum[BIT_DEPTH-1:0];
        end
    end

    assign addr_full = (((ADDR_W'(lcu_y_q) << LCU_LOG2) + ADDR_W'(row)) << PIC_W_LOG2)
                     + (ADDR_W'(lcu_x_q) << LCU_LOG2) + ADDR_W'(col);

    assign busy      = busy_q;
    assign finish    = (state_q == S_DONE);
    assign sram_cen  = (state_q != S_PROC);
    assign sram_wen  = (state_q != S_PROC);
    assign sram_addr = (state_q == S_PROC) ? addr_full : '0;
    assign sram_d    = (state_q == S_PROC) ? res : '0;

endmodule
